scan_chain_ctrl: RTL and testbench
==================================

SCAN_CHAIN_CTRL -- requirements
Module: scan_chain_ctrl

Interface
REQ-001 The block SHALL have parameter CHAIN_LEN, default 32, giving the number of scan flops in the driven chain (legal range 2..256).
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the shift counter width; CNT_W SHALL satisfy 2**CNT_W > CHAIN_LEN.
REQ-003 The block SHALL have port CLK, input, 1 bit: clock; all state updates on its rising edge.
REQ-004 The block SHALL have port RSTB, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port start, input, 1 bit: request one load/capture/unload sequence.
REQ-006 The block SHALL have port abort, input, 1 bit: synchronous cancel of the running sequence.
REQ-007 The block SHALL have port pattern, input, CHAIN_LEN bits: stimulus; bit i targets chain flop i, where flop CHAIN_LEN-1 is the tail driving so_i.
REQ-008 The block SHALL have port so_i, input, 1 bit: scan-out from the chain tail.
REQ-009 The block SHALL have port se_o, output, 1 bit: scan enable to every chain flop SE pin.
REQ-010 The block SHALL have port si_o, output, 1 bit: scan-in to chain flop 0 SI pin.
REQ-011 The block SHALL have port busy, output, 1 bit: sequence in progress.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-013 The block SHALL have port aborted, output, 1 bit: one-cycle pulse on accepted abort.
REQ-014 The block SHALL have port response, output, CHAIN_LEN bits: captured chain contents; bit i is the value captured by flop i.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, CAPTURE, UNLOAD, DONE.
REQ-016 In IDLE, start=1 SHALL latch pattern into an internal shift register and move to LOAD; in other states start SHALL be ignored.
REQ-017 se_o, si_o, busy, done and aborted SHALL be registered outputs, with no combinational path from any input.
REQ-018 LOAD SHALL last exactly CHAIN_LEN cycles with se_o=1; si_o SHALL present pattern[CHAIN_LEN-1] in the first cycle, then pattern[CHAIN_LEN-2], down to pattern[0] in the last cycle.
REQ-019 CAPTURE SHALL last exactly 1 cycle with se_o=0 and si_o=0.
REQ-020 UNLOAD SHALL last exactly CHAIN_LEN cycles with se_o=1 and si_o=0.
REQ-021 In UNLOAD, so_i SHALL be sampled at each cycle's closing edge: the first sample goes to response[CHAIN_LEN-1] and the last to response[0].
REQ-022 response SHALL change only during UNLOAD and SHALL hold its value afterwards until the next UNLOAD or reset.
REQ-023 DONE SHALL last 1 cycle with done=1 and se_o=0, then the FSM SHALL return to IDLE.
REQ-024 With start accepted at edge k, done SHALL be high during the cycle after edge k+2*CHAIN_LEN+2.
REQ-025 busy SHALL be high from the edge after start acceptance through the DONE cycle inclusive, and low in IDLE.
REQ-026 The shift counter SHALL count 0..CHAIN_LEN-1 and reset to 0 on every LOAD/UNLOAD entry; it SHALL have no wrap beyond CHAIN_LEN-1.
REQ-027 abort=1 in LOAD, CAPTURE or UNLOAD SHALL, at the next edge: move the FSM to IDLE, set se_o=0 and si_o=0, pulse aborted for 1 cycle, leave done low, and leave response unchanged from its last completed bit.
REQ-028 abort in IDLE or DONE SHALL be ignored; in DONE, the done pulse SHALL still occur.
REQ-029 When start and abort are both high in IDLE, abort SHALL win and the sequence SHALL not start.

Reset
REQ-030 RSTB=0 SHALL immediately force state IDLE, se_o=0, si_o=0, busy=0, done=0, aborted=0, response=0, and counter=0, independent of CLK.
REQ-031 Reset asserted mid-sequence SHALL discard all progress; the first start after RSTB rises SHALL begin a full new sequence.
REQ-032 On the first edge after RSTB rises, the block SHALL remain in IDLE unless start=1.

Verification
REQ-033 Normal sequence: CHAIN_LEN=4 with four SDFFARX2 cells, D inputs tied to 4'b0110, pattern=4'b1011 -> si_o=1,0,1,1 over 4 LOAD cycles; chain Q=1011 before CAPTURE; response=4'b0110; done at edge 10.
REQ-034 Loopback: so_i tied to si_o of a 4-flop chain with SE held by se_o and D=Q -> response equals pattern for patterns 0000, 1111, 1010.
REQ-035 Abort in UNLOAD after 2 samples -> aborted=1 for one cycle, done never asserts, se_o=0 on the next cycle, response[3:2] updated and response[1:0] at prior values.
REQ-036 Async reset asserted mid-LOAD between clock edges -> all outputs 0 before the next edge; a new start gives a complete correct sequence.
REQ-037 Back-to-back: start held high continuously -> second sequence begins the cycle after DONE, with exactly 1 IDLE cycle between done and the next busy.
REQ-038 start with abort=1 in IDLE -> busy stays 0 and no se_o activity occurs.

Source files
------------

// File: rtl/scan_chain_ctrl.sv
// Scan chain sequencer: shifts a stimulus pattern into an external scan chain,
// pulses one capture cycle, then shifts the captured chain contents back out.
module scan_chain_ctrl #(
    parameter int CHAIN_LEN = 32,
    parameter int CNT_W     = 8
) (
    input  logic                 CLK,
    input  logic                 RSTB,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CHAIN_LEN-1:0] pattern,
    input  logic                 so_i,
    output logic                 se_o,
    output logic                 si_o,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted,
    output logic [CHAIN_LEN-1:0] response
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CAPTURE,
        UNLOAD,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]     uidx_q, uidx_d;
    logic [CHAIN_LEN-1:0] shreg_q, shreg_d;
    logic [CHAIN_LEN-1:0] resp_q, resp_d;
    logic                 se_q, se_d;
    logic                 si_q, si_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 abt_q, abt_d;
    logic                 unl_q, unl_d;

    logic abort_take;
    logic last_cnt;

    assign abort_take = abort && (state_q inside {LOAD, CAPTURE, UNLOAD});
    assign last_cnt   = (cnt_q == LAST_CNT);

    // Outputs are registered from the current state, so the pins trail the
    // FSM by one cycle; unl_q/uidx_q mark which UNLOAD cycle the pins show.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path
        // leaves it unassigned, which would infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        resp_d  = resp_q;
        se_d    = 1'b0;
        si_d    = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        abt_d   = 1'b0;
        unl_d   = 1'b0;
        uidx_d  = '0;

        // First so_i sample lands in the top bit, the last in bit 0.
        if (unl_q && !abort_take) begin
            for (int i = 0; i < CHAIN_LEN; i++) begin
                if (i == CHAIN_LEN - 1 - int'(uidx_q)) begin
                    resp_d[i] = so_i;
                end
            end
        end

        if (abort_take) begin
            state_d = IDLE;
            cnt_d   = '0;
            abt_d   = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        state_d = LOAD;
                        cnt_d   = '0;
                        shreg_d = pattern;
                    end
                end
                LOAD: begin
                    se_d    = 1'b1;
                    si_d    = shreg_q[CHAIN_LEN-1];
                    busy_d  = 1'b1;
                    shreg_d = {shreg_q[CHAIN_LEN-2:0], 1'b0};
                    if (last_cnt) begin
                        state_d = CAPTURE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                CAPTURE: begin
                    busy_d  = 1'b1;
                    state_d = UNLOAD;
                    cnt_d   = '0;
                end
                UNLOAD: begin
                    se_d   = 1'b1;
                    busy_d = 1'b1;
                    unl_d  = 1'b1;
                    uidx_d = cnt_q;
                    if (last_cnt) begin
                        state_d = DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    busy_d  = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            uidx_q  <= '0;
            shreg_q <= '0;
            resp_q  <= '0;
            se_q    <= 1'b0;
            si_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            abt_q   <= 1'b0;
            unl_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            uidx_q  <= uidx_d;
            shreg_q <= shreg_d;
            resp_q  <= resp_d;
            se_q    <= se_d;
            si_q    <= si_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            abt_q   <= abt_d;
            unl_q   <= unl_d;
        end
    end

    assign se_o     = se_q;
    assign si_o     = si_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign aborted  = abt_q;
    assign response = resp_q;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Directed bench for scan_chain_ctrl driving a 4-flop scan chain model whose
// capture data is either a fixed D vector or its own Q (loopback).
module tb_scan_chain_ctrl;

    localparam int N = 4;

    logic         CLK = 1'b0;
    logic         RSTB = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [N-1:0] pattern = '0;
    logic         so_i;
    logic         se_o, si_o, busy, done, aborted;
    logic [N-1:0] response;

    logic [N-1:0] chain;
    logic [N-1:0] d_in = '0;
    logic         loopback = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    scan_chain_ctrl #(.CHAIN_LEN(N), .CNT_W(3)) dut (
        .CLK      (CLK),
        .RSTB     (RSTB),
        .start    (start),
        .abort    (abort),
        .pattern  (pattern),
        .so_i     (so_i),
        .se_o     (se_o),
        .si_o     (si_o),
        .busy     (busy),
        .done     (done),
        .aborted  (aborted),
        .response (response)
    );

    // Flop 0 takes si_o, flop N-1 drives so_i.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB)         chain <= '0;
        else if (se_o)     chain <= {chain[N-2:0], si_o};
        else if (loopback) chain <= chain;
        else               chain <= d_in;
    end
    assign so_i = chain[N-1];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Start a sequence and wait for done; expects done exactly 10 cycles later.
    task automatic run_seq(input logic [N-1:0] pat, input logic [N-1:0] exp_resp, input string tag);
        int c;
        pattern = pat;
        start   = 1'b1;
        tick();
        start = 1'b0;
        c = 0;
        while (!done && c < 30) begin
            tick();
            c++;
        end
        n_cmp++;
        if (c !== 10) begin
            n_bad++;
            $display("FAIL %s_latency: done after %0d cycles, expected 10", tag, c);
        end
        n_cmp++;
        if (response !== exp_resp) begin
            n_bad++;
            $display("FAIL %s_response: got %b expected %b", tag, response, exp_resp);
        end
        tick();
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if ({busy, se_o, si_o, done, aborted} !== 5'b00000 || response !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b/%b expected 00000/0000",
                     {busy, se_o, si_o, done, aborted}, response);
        end
        #20 RSTB = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_normal();
        logic [4:0] exp_o [12];
        // {busy, se_o, si_o, done, aborted} for cycles 0..11 after acceptance
        exp_o = '{5'b00000, 5'b11100, 5'b11000, 5'b11100, 5'b11100, 5'b10000,
                  5'b11000, 5'b11000, 5'b11000, 5'b11000, 5'b10010, 5'b00000};
        loopback = 1'b0;
        d_in     = 4'b0110;
        pattern  = 4'b1011;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j < 12; j++) begin
            n_cmp++;
            if ({busy, se_o, si_o, done, aborted} !== exp_o[j]) begin
                n_bad++;
                $display("FAIL normal_cycle%0d: got %b expected %b", j,
                         {busy, se_o, si_o, done, aborted}, exp_o[j]);
            end
            if (j == 5) begin
                n_cmp++;
                if (chain !== 4'b1011) begin
                    n_bad++;
                    $display("FAIL normal_chain_loaded: got %b expected 1011", chain);
                end
            end
            tick();
        end
        n_cmp++;
        if (response !== 4'b0110) begin
            n_bad++;
            $display("FAIL normal_response: got %b expected 0110", response);
        end
    endtask

    task automatic test_loopback();
        loopback = 1'b1;
        run_seq(4'b0000, 4'b0000, "loop0000");
        run_seq(4'b1111, 4'b1111, "loop1111");
        run_seq(4'b1010, 4'b1010, "loop1010");
    endtask

    task automatic test_abort_unload();
        int done_seen;
        loopback = 1'b0;
        d_in     = 4'b0101;
        pattern  = 4'b0011;
        start    = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        n_cmp++;
        if (se_o !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_pre_se: se_o=%b expected 1", se_o);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_cmp++;
        if ({busy, se_o, si_o, done, aborted} !== 5'b00001) begin
            n_bad++;
            $display("FAIL abort_pulse: got %b expected 00001", {busy, se_o, si_o, done, aborted});
        end
        // Two samples taken (captured bits 3,2 = 0,1); low bits keep 1010's.
        n_cmp++;
        if (response !== 4'b0110) begin
            n_bad++;
            $display("FAIL abort_response: got %b expected 0110", response);
        end
        tick();
        n_cmp++;
        if (aborted !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_one_cycle: aborted=%b expected 0", aborted);
        end
        done_seen = 0;
        repeat (12) begin
            if (done === 1'b1 || busy === 1'b1) done_seen++;
            tick();
        end
        n_cmp++;
        if (done_seen !== 0) begin
            n_bad++;
            $display("FAIL abort_no_done: done/busy high %0d cycles, expected 0", done_seen);
        end
    endtask

    task automatic test_abort_done();
        loopback = 1'b1;
        pattern  = 4'b1001;
        start    = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_cmp++;
        if ({done, aborted} !== 2'b10) begin
            n_bad++;
            $display("FAIL abort_in_done: done/aborted=%b expected 10", {done, aborted});
        end
        n_cmp++;
        if (response !== 4'b1001) begin
            n_bad++;
            $display("FAIL abort_in_done_response: got %b expected 1001", response);
        end
        tick();
    endtask

    task automatic test_async_reset();
        loopback = 1'b1;
        pattern  = 4'b1100;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2 RSTB = 1'b0;
        #1;
        n_cmp++;
        if ({busy, se_o, si_o, done, aborted} !== 5'b00000 || response !== '0) begin
            n_bad++;
            $display("FAIL async_reset: got %b/%b expected 00000/0000",
                     {busy, se_o, si_o, done, aborted}, response);
        end
        #2 RSTB = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset_idle: busy=%b expected 0", busy);
        end
        run_seq(4'b1100, 4'b1100, "after_reset");
    endtask

    task automatic test_back_to_back();
        int c;
        loopback = 1'b1;
        pattern  = 4'b0101;
        start    = 1'b1;
        tick();
        for (int j = 0; j < 22; j++) begin
            if (j == 10 || j == 21) begin
                n_cmp++;
                if (done !== 1'b1) begin
                    n_bad++;
                    $display("FAIL b2b_done_cycle%0d: done=%b expected 1", j, done);
                end
            end
            if (j == 11) begin
                n_cmp++;
                if ({busy, done} !== 2'b00) begin
                    n_bad++;
                    $display("FAIL b2b_gap: busy/done=%b expected 00", {busy, done});
                end
            end
            if (j == 12) begin
                n_cmp++;
                if (busy !== 1'b1) begin
                    n_bad++;
                    $display("FAIL b2b_restart: busy=%b expected 1", busy);
                end
            end
            if (j == 21) start = 1'b0;
            tick();
        end
        c = 0;
        while (busy && c < 30) begin
            tick();
            c++;
        end
        n_cmp++;
        if (busy !== 1'b0 || response !== 4'b0101) begin
            n_bad++;
            $display("FAIL b2b_end: busy=%b response=%b expected 0/0101", busy, response);
        end
    endtask

    task automatic test_start_abort();
        int active;
        start  = 1'b1;
        abort  = 1'b1;
        active = 0;
        repeat (6) begin
            tick();
            if (busy !== 1'b0 || se_o !== 1'b0 || aborted !== 1'b0) active++;
        end
        start = 1'b0;
        abort = 1'b0;
        tick();
        if (busy !== 1'b0) active++;
        n_cmp++;
        if (active !== 0) begin
            n_bad++;
            $display("FAIL start_abort_idle: %0d active cycles, expected 0", active);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_normal();
        test_loopback();
        test_abort_unload();
        test_abort_done();
        test_async_reset();
        test_back_to_back();
        test_start_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
